present_nibble_seq: RTL and testbench
=====================================

PRESENT_NIBBLE_SEQ -- requirements
Module: present_nibble_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the max cycles to wait for engine completion before flagging an error.
REQ-002 SHALL have port Clk_ik  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port Reset_ir  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port InData_ib  in  4  host nibble stream.
REQ-005 SHALL have port InValid_i  in  1  host nibble valid.
REQ-006 SHALL have port InReady_o  out  1  sequencer accepts nibble.
REQ-007 SHALL have port OutData_ob  out  4  ciphertext nibble stream.
REQ-008 SHALL have port OutValid_o  out  1  output nibble valid.
REQ-009 SHALL have port OutReady_i  in  1  host accepts output nibble.
REQ-010 SHALL have port PlainText_ob  out  64  engine plaintext.
REQ-011 SHALL have port Key_ob  out  80  engine key.
REQ-012 SHALL have port CipherText_ib  in  64  engine ciphertext.
REQ-013 SHALL have port Start_o  out  1  engine start pulse.
REQ-014 SHALL have port EngReady_i  in  1  engine idle/done.
REQ-015 SHALL have port Busy_o  out  1  high in any state other than IDLE.
REQ-016 SHALL have port Error_o  out  1  sticky timeout flag.
REQ-017 SHALL have port ErrClear_i  in  1  clears Error_o.

Function
REQ-018 SHALL transfer a nibble on a cycle where valid and ready are both high (input and output streams alike); nibbles travel LS-nibble first, so nibble n maps to bits [4n+3:4n].
REQ-019 SHALL implement the states IDLE, KEY, PT, START, WAIT_LO, WAIT_HI and OUT.
REQ-020 SHALL accept in IDLE one header nibble: bit0 = load key, bit1 = CBC mode, bit2 = clear chain register, bit3 reserved and ignored.
REQ-021 SHALL go from IDLE to KEY when bit0 = 1, otherwise to PT; header bit2 zeroes the 64-bit chain register in the same cycle.
REQ-022 SHALL accept exactly 20 nibbles in KEY into Key_ob, then go to PT; Key_ob holds its value across frames until reloaded.
REQ-023 SHALL accept exactly 16 nibbles in PT into the plaintext register, then go to START.
REQ-024 SHALL drive PlainText_ob = plaintext XOR chain when the latched CBC bit = 1, else plaintext.
REQ-025 SHALL, in START, assert Start_o for exactly one cycle once EngReady_i = 1, then go to WAIT_LO.
REQ-026 SHALL go from WAIT_LO to WAIT_HI when EngReady_i = 0, and from WAIT_HI to OUT when EngReady_i = 1; on that transition it SHALL capture CipherText_ib into the output shadow and into the chain register.
REQ-027 SHALL run one watchdog counter from START through WAIT_HI; reaching TIMEOUT_CYCLES sets Error_o, returns to IDLE and produces no output.
REQ-028 SHALL present 16 shadow nibbles in OUT with OutValid_o held until accepted; OutData_ob is stable while OutValid_o = 1 and OutReady_i = 0; after the 16th transfer it returns to IDLE.
REQ-029 SHALL hold InReady_o = 1 only in IDLE, KEY and PT; OutValid_o = 1 only in OUT.
REQ-030 SHALL clear Error_o via ErrClear_i; if ErrClear_i and a timeout coincide, the set wins.
REQ-031 SHALL use nibble counters 5 bits wide that reset to 0 on every state entry; the watchdog counter is clog2(TIMEOUT_CYCLES+1) bits wide.

Reset
REQ-032 SHALL, on Reset_ir, asynchronously enter IDLE and zero all counters, Key_ob, PlainText_ob, chain, shadow, Start_o, OutValid_o, Busy_o and Error_o; InReady_o = 1.
REQ-033 SHALL abort any frame mid-operation on reset without emitting any output.

Structure
REQ-034 SHALL take the state encodings, header bit positions, nibble counts (20/16) and default timeout from the shared package present_seq_pkg.
REQ-035 SHALL instantiate one sub-module, present_nib_shreg (a parameterised-width nibble shift-in register), for the key and plaintext; core_serial is instantiated outside this block.

Verification
REQ-036 SHALL cover: header 0x1, 20×0x0 key, 16×0x0 pt with real core_serial -> output 5579C1387B228445 (LS nibble 0x5 first).
REQ-037 SHALL cover: header 0x1, key all 0xF, pt zero -> output E72C46C0F5945049.
REQ-038 SHALL cover: header 0x6 after a prior frame, pt zero -> PlainText_ob = 0, key unchanged; second frame header 0x2, pt zero -> PlainText_ob equals the first ciphertext.
REQ-039 SHALL cover: engine model that never raises EngReady_i, TIMEOUT_CYCLES = 15 -> Error_o = 1 within 17 cycles of Start_o, state IDLE, no OutValid_o.
REQ-040 SHALL cover: OutReady_i toggling 1-in-3 during OUT -> all 16 nibbles delivered in order with no duplicates; Reset_ir mid-KEY -> IDLE and Busy_o = 0 immediately.

Source files
------------

// File: rtl/present_nibble_seq_pkg.sv
// Shared definitions for the PRESENT nibble sequencer: state encoding,
// header bit positions, frame nibble counts and the default watchdog limit.
package present_seq_pkg;

    localparam int NIB_W           = 4;
    localparam int NIB_CNT_W       = 5;
    localparam int KEY_W           = 80;
    localparam int BLK_W           = 64;
    localparam int KEY_NIBBLES     = KEY_W / NIB_W;
    localparam int PT_NIBBLES      = BLK_W / NIB_W;
    localparam int DEFAULT_TIMEOUT = 1023;

    localparam int HDR_LOAD_KEY  = 0;
    localparam int HDR_CBC       = 1;
    localparam int HDR_CLR_CHAIN = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEY     = 3'd1,
        ST_PT      = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_OUT     = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic load_key;
        logic cbc;
        logic clr_chain;
    } hdr_t;

    // Bit 3 of the header is reserved and deliberately dropped here.
    function automatic hdr_t decode_hdr(input logic [NIB_W-1:0] nib);
        hdr_t h;
        h.load_key  = nib[HDR_LOAD_KEY];
        h.cbc       = nib[HDR_CBC];
        h.clr_chain = nib[HDR_CLR_CHAIN];
        return h;
    endfunction

    function automatic logic is_last_nib(input logic [NIB_CNT_W-1:0] cnt, input int total);
        return cnt == NIB_CNT_W'(total - 1);
    endfunction

endpackage

// File: rtl/present_nibble_seq_if.sv
// Host nibble streams plus the parallel bus to the PRESENT engine.
// The sequencer uses the slave view; host/engine models use the master view.
interface present_nibble_seq_if;
    import present_seq_pkg::*;

    logic [NIB_W-1:0] InData_ib;
    logic             InValid_i;
    logic             InReady_o;
    logic [NIB_W-1:0] OutData_ob;
    logic             OutValid_o;
    logic             OutReady_i;
    logic [BLK_W-1:0] PlainText_ob;
    logic [KEY_W-1:0] Key_ob;
    logic [BLK_W-1:0] CipherText_ib;
    logic             Start_o;
    logic             EngReady_i;

    modport slave (
        input  InData_ib, InValid_i, OutReady_i, CipherText_ib, EngReady_i,
        output InReady_o, OutData_ob, OutValid_o, PlainText_ob, Key_ob, Start_o
    );

    modport master (
        output InData_ib, InValid_i, OutReady_i, CipherText_ib, EngReady_i,
        input  InReady_o, OutData_ob, OutValid_o, PlainText_ob, Key_ob, Start_o
    );

endinterface

// File: rtl/present_nibble_seq_shreg.sv
// Nibble shift-in register: each accepted nibble enters at the top and moves
// down, so after WIDTH/4 shifts the first nibble sits in bits [3:0].
module present_nib_shreg
    import present_seq_pkg::*;
#(
    parameter int WIDTH = BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [NIB_W-1:0] nib_in,
    output logic [WIDTH-1:0] data_o
);
    localparam int NIBS = WIDTH / NIB_W;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    generate
        for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib
            if (gi == NIBS - 1) begin : g_top
                assign data_d[NIB_W*gi +: NIB_W] = shift_en ? nib_in : data_q[NIB_W*gi +: NIB_W];
            end else begin : g_low
                assign data_d[NIB_W*gi +: NIB_W] = shift_en ? data_q[NIB_W*(gi+1) +: NIB_W]
                                                            : data_q[NIB_W*gi +: NIB_W];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/present_nibble_seq.sv
// Frame sequencer for a PRESENT-80 engine: collects header/key/plaintext
// nibbles, runs one engine operation under a watchdog and streams the result.
module present_nibble_seq
    import present_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                  Clk_ik,
    input  logic                  Reset_ir,
    present_nibble_seq_if.slave   bus,
    input  logic                  ErrClear_i,
    output logic                  Busy_o,
    output logic                  Error_o
);
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    seq_state_e           state_q,  state_d;
    logic [NIB_CNT_W-1:0] cnt_q,    cnt_d;
    logic [WD_W-1:0]      wd_q,     wd_d;
    logic                 cbc_q,    cbc_d;
    logic                 start_q,  start_d;
    logic                 err_q,    err_d;
    logic [BLK_W-1:0]     chain_q,  chain_d;
    logic [BLK_W-1:0]     shadow_q, shadow_d;

    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;
    logic [KEY_W-1:0] key_w;
    logic [BLK_W-1:0] pt_w;
    hdr_t             hdr;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_KEY) || (state_q == ST_PT);
    assign out_valid = (state_q == ST_OUT);
    assign in_fire   = bus.InValid_i && in_ready;
    assign out_fire  = out_valid && bus.OutReady_i;
    assign hdr       = decode_hdr(bus.InData_ib);

    present_nib_shreg #(
        .WIDTH (KEY_W)
    ) u_key_shreg (
        .clk      (Clk_ik),
        .rst      (Reset_ir),
        .shift_en (in_fire && (state_q == ST_KEY)),
        .nib_in   (bus.InData_ib),
        .data_o   (key_w)
    );

    present_nib_shreg #(
        .WIDTH (BLK_W)
    ) u_pt_shreg (
        .clk      (Clk_ik),
        .rst      (Reset_ir),
        .shift_en (in_fire && (state_q == ST_PT)),
        .nib_in   (bus.InData_ib),
        .data_o   (pt_w)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        cbc_d    = cbc_q;
        start_d  = 1'b0;
        err_d    = err_q;
        chain_d  = chain_q;
        shadow_d = shadow_q;

        // Clear first so that a simultaneous timeout below overrides it.
        if (ErrClear_i) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    cbc_d = hdr.cbc;
                    if (hdr.clr_chain) begin
                        chain_d = '0;
                    end
                    state_d = hdr.load_key ? ST_KEY : ST_PT;
                end
            end
            ST_KEY: begin
                if (in_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_last_nib(cnt_q, KEY_NIBBLES)) begin
                        state_d = ST_PT;
                    end
                end
            end
            ST_PT: begin
                if (in_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_last_nib(cnt_q, PT_NIBBLES)) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START, ST_WAIT_LO, ST_WAIT_HI: begin
                wd_d = wd_q + 1'b1;
                if (wd_q == WD_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_START) begin
                    if (bus.EngReady_i) begin
                        start_d = 1'b1;
                        state_d = ST_WAIT_LO;
                    end
                end else if (state_q == ST_WAIT_LO) begin
                    if (!bus.EngReady_i) begin
                        state_d = ST_WAIT_HI;
                    end
                end else if (bus.EngReady_i) begin
                    shadow_d = bus.CipherText_ib;
                    chain_d  = bus.CipherText_ib;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_last_nib(cnt_q, PT_NIBBLES)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state starts counting nibbles from zero; the watchdog spans
        // START..WAIT_HI so it is only rearmed when START is entered.
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == ST_START) begin
                wd_d = '0;
            end
        end
    end

    always_ff @(posedge Clk_ik or posedge Reset_ir) begin
        if (Reset_ir) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wd_q     <= '0;
            cbc_q    <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            chain_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            cbc_q    <= cbc_d;
            start_q  <= start_d;
            err_q    <= err_d;
            chain_q  <= chain_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.InReady_o    = in_ready;
    assign bus.OutValid_o   = out_valid;
    assign bus.OutData_ob   = shadow_q[{cnt_q[3:0], 2'b00} +: NIB_W];
    assign bus.PlainText_ob = cbc_q ? (pt_w ^ chain_q) : pt_w;
    assign bus.Key_ob       = key_w;
    assign bus.Start_o      = start_q;
    assign Busy_o           = (state_q != ST_IDLE);
    assign Error_o          = err_q;

endmodule

// File: tb/tb_present_nibble_seq.sv
// Randomised frame-level bench: a behavioural PRESENT-80 engine and a
// frame/chain reference model predict every plaintext, key and ciphertext.
module tb_present_nibble_seq;

    logic clk;
    logic rst;
    logic err_clr;
    logic busy;
    logic error;
    bit   hang_mode;

    int checks;
    int errors;

    logic [79:0] m_key;
    logic [63:0] m_chain;
    logic        m_cbc;

    present_nibble_seq_if bus ();

    present_nibble_seq #(
        .TIMEOUT_CYCLES (15)
    ) dut (
        .Clk_ik     (clk),
        .Reset_ir   (rst),
        .bus        (bus),
        .ErrClear_i (err_clr),
        .Busy_o     (busy),
        .Error_o    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // PRESENT-80 straight from the cipher definition.
    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
        logic [3:0]  sbox [16];
        logic [63:0] s;
        logic [63:0] p;
        logic [79:0] k;
        sbox = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox[s[4*i +: 4]];
            p = '0;
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Engine model: takes a start, drops ready, answers after a short latency
    // (or never, while hang_mode is set).
    initial begin
        logic [63:0] eng_pt;
        logic [79:0] eng_key;
        int          lat;
        bus.EngReady_i    = 1'b1;
        bus.CipherText_ib = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.Start_o) begin
                eng_pt  = bus.PlainText_ob;
                eng_key = bus.Key_ob;
                bus.EngReady_i = 1'b0;
                lat = $urandom_range(1, 6);
                @(posedge clk);
                #1;
                check_val("start_one_cycle", 80'(bus.Start_o), 80'(1'b0));
                repeat (lat - 1) @(posedge clk);
                while (hang_mode) @(posedge clk);
                #1;
                bus.CipherText_ib = present_enc(eng_pt, eng_key);
                bus.EngReady_i    = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic send_nib(input logic [3:0] n);
        int   b;
        int   guard;
        logic took;
        b = $urandom_range(0, 2);
        repeat (b) begin
            @(posedge clk);
            #1;
        end
        bus.InData_ib  = n;
        bus.InValid_i  = 1'b1;
        guard = 0;
        took  = 1'b0;
        while (!took && guard < 50) begin
            @(negedge clk);
            took = bus.InReady_o;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.InValid_i = 1'b0;
        check_val("in_accept", 80'(took), 80'(1'b1));
    endtask

    // rmode: 0 = always ready, 1 = ready one cycle in three, 2 = random
    task automatic recv_block(input int rmode, output logic [63:0] ct);
        int         got;
        int         cyc;
        logic       stalled;
        logic [3:0] held;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        ct      = '0;
        while (got < 16 && cyc < 400) begin
            case (rmode)
                0:       bus.OutReady_i = 1'b1;
                1:       bus.OutReady_i = (cyc % 3 == 0);
                default: bus.OutReady_i = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (bus.OutValid_o) begin
                if (stalled) check_val("out_stable", 80'(bus.OutData_ob), 80'(held));
                if (bus.OutReady_i) begin
                    ct[4*got +: 4] = bus.OutData_ob;
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.OutData_ob;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.OutReady_i = 1'b0;
        check_val("out_count", 80'(got), 80'(16));
    endtask

    task automatic run_frame(input logic [3:0] hdr, input logic [79:0] key, input logic [63:0] pt,
                             input int rmode, output logic [63:0] ct_got, output logic [63:0] pt_seen);
        logic [63:0] exp_pt;
        logic [63:0] exp_ct;
        if (hdr[2]) m_chain = '0;
        if (hdr[0]) m_key = key;
        m_cbc = hdr[1];
        send_nib(hdr);
        if (hdr[0]) for (int i = 0; i < 20; i++) send_nib(key[4*i +: 4]);
        for (int i = 0; i < 16; i++) send_nib(pt[4*i +: 4]);
        exp_pt  = m_cbc ? (pt ^ m_chain) : pt;
        pt_seen = bus.PlainText_ob;
        check_val("pt_ob", 80'(pt_seen), 80'(exp_pt));
        check_val("key_ob", bus.Key_ob, m_key);
        check_val("busy_frame", 80'(busy), 80'(1'b1));
        exp_ct = present_enc(exp_pt, m_key);
        recv_block(rmode, ct_got);
        check_val("ct", 80'(ct_got), 80'(exp_ct));
        check_val("idle_after_out", 80'(busy), 80'(1'b0));
        m_chain = exp_ct;
        $display("frame hdr=%h key=%h pt_ob=%h ct=%h", hdr, m_key, pt_seen, ct_got);
    endtask

    initial begin
        logic [63:0] ct;
        logic [63:0] pts;
        logic [63:0] ct_first;
        logic [3:0]  hdr;
        int          n;
        logic        saw_out;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        err_clr = 1'b0;
        hang_mode = 1'b0;
        bus.InValid_i = 1'b0;
        bus.InData_ib = '0;
        bus.OutReady_i = 1'b0;
        m_key = '0;
        m_chain = '0;
        m_cbc = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 80'(busy), 80'(1'b0));
        check_val("rst_error", 80'(error), 80'(1'b0));
        check_val("rst_in_ready", 80'(bus.InReady_o), 80'(1'b1));
        check_val("rst_out_valid", 80'(bus.OutValid_o), 80'(1'b0));
        check_val("rst_start", 80'(bus.Start_o), 80'(1'b0));
        check_val("rst_key", bus.Key_ob, 80'(0));
        check_val("rst_pt", 80'(bus.PlainText_ob), 80'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame(4'h1, 80'h0, 64'h0, 0, ct, pts);
        check_val("kat_zero_key", 80'(ct), 80'(64'h5579C1387B228445));
        run_frame(4'h1, {80{1'b1}}, 64'h0, 0, ct, pts);
        check_val("kat_ones_key", 80'(ct), 80'(64'hE72C46C0F5945049));
        run_frame(4'h6, 80'h0, 64'h0, 2, ct_first, pts);
        check_val("cbc_clr_pt", 80'(pts), 80'(0));
        check_val("key_kept", bus.Key_ob, {80{1'b1}});
        run_frame(4'h2, 80'h0, 64'h0, 1, ct, pts);
        check_val("cbc_chain_pt", 80'(pts), 80'(ct_first));

        for (int f = 0; f < 6; f++) begin
            hdr = 4'($urandom_range(0, 15));
            run_frame(hdr, {16'($urandom), $urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 2), ct, pts);
        end

        // Engine that never answers.
        hang_mode = 1'b1;
        hdr = {1'($urandom_range(0, 1)), 3'b000};
        m_cbc = 1'b0;
        send_nib(hdr);
        for (int i = 0; i < 16; i++) send_nib(4'($urandom));
        n = 0;
        while (!bus.Start_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("tmo_start_seen", 80'(bus.Start_o), 80'(1'b1));
        n = 0;
        saw_out = 1'b0;
        while (!error && n < 17) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.OutValid_o) saw_out = 1'b1;
        end
        check_val("tmo_error", 80'(error), 80'(1'b1));
        check_val("tmo_idle", 80'(busy), 80'(1'b0));
        check_val("tmo_no_out", 80'(saw_out), 80'(1'b0));
        check_val("tmo_in_ready", 80'(bus.InReady_o), 80'(1'b1));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("tmo_sticky", 80'(error), 80'(1'b1));
        check_val("tmo_still_no_out", 80'(bus.OutValid_o), 80'(1'b0));
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_val("err_cleared", 80'(error), 80'(1'b0));
        $display("timeout frame hdr=%h error after %0d cycles", hdr, n);
        hang_mode = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end

        // Reset in the middle of key loading.
        send_nib(4'h1);
        for (int i = 0; i < 7; i++) send_nib(4'($urandom));
        check_val("mid_key_busy", 80'(busy), 80'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 80'(busy), 80'(1'b0));
        check_val("abort_key", bus.Key_ob, 80'(0));
        check_val("abort_pt", 80'(bus.PlainText_ob), 80'(0));
        check_val("abort_in_ready", 80'(bus.InReady_o), 80'(1'b1));
        check_val("abort_out_valid", 80'(bus.OutValid_o), 80'(1'b0));
        $display("reset applied mid-KEY");
        m_key = '0;
        m_chain = '0;
        m_cbc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(4'h0, 80'h0, {$urandom, $urandom}, 2, ct, pts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
